// File: rtl/ram_sdp_multird.sv
// Simple-dual-port RAM with one write port and RD_PORTS independent read channels.
// A CLEAR/RUN FSM zeroes every entry after reset or on request before accesses are served.
module ram_sdp_multird #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 16,
    parameter int RD_PORTS  = 2,
    parameter int OUT_REG   = 0,
    parameter int WR_BYPASS = 1,
    localparam int AW = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    input  logic                          i_wr_en,
    input  logic [AW-1:0]                 i_wr_addr,
    input  logic [RAM_WIDTH-1:0]          i_wr_data,
    input  logic [RD_PORTS-1:0]           i_rd_en,
    input  logic [RD_PORTS*AW-1:0]        i_rd_addr,
    output logic [RD_PORTS*RAM_WIDTH-1:0] o_rd_data,
    output logic [RD_PORTS-1:0]           o_rd_vld,
    output logic                          o_ready,
    output logic                          o_addr_err
);

    // AW+1 bits so a power-of-two depth still fits for the range compare
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST_L  = AW'(RAM_DEPTH - 1);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                        state_r;
    logic [AW-1:0]                 clr_cnt_r;
    logic                          ready_r;
    logic [RAM_WIDTH-1:0]          mem_r [RAM_DEPTH];
    logic                          run_s;
    logic                          wr_ok_s;
    logic                          err_s;
    logic [RD_PORTS-1:0]           rd_acc_s;
    logic [RD_PORTS*RAM_WIDTH-1:0] rd_val_s;
    logic [RD_PORTS-1:0]           vld1_r;
    logic [RD_PORTS*RAM_WIDTH-1:0] data1_r;
    logic                          err_r;

    assign run_s = (state_r == ST_RUN);

    // Access decode: range check, read mux with optional write-first bypass
    always_comb begin
        wr_ok_s  = 1'b0;
        err_s    = 1'b0;
        rd_acc_s = '0;
        rd_val_s = '0;
        if (run_s && i_wr_en) begin
            if ({1'b0, i_wr_addr} < DEPTH_L) begin
                wr_ok_s = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            wr_ok_s = 1'b0;
        end
        for (int k = 0; k < RD_PORTS; k++) begin
            if (run_s && i_rd_en[k]) begin
                rd_acc_s[k] = 1'b1;
                if ({1'b0, i_rd_addr[k*AW +: AW]} >= DEPTH_L) begin
                    err_s = 1'b1;
                end else if ((WR_BYPASS != 0) && wr_ok_s && (i_wr_addr == i_rd_addr[k*AW +: AW])) begin
                    rd_val_s[k*RAM_WIDTH +: RAM_WIDTH] = i_wr_data;
                end else begin
                    rd_val_s[k*RAM_WIDTH +: RAM_WIDTH] = mem_r[i_rd_addr[k*AW +: AW]];
                end
            end else begin
                rd_acc_s[k] = 1'b0;
            end
        end
    end

    // Storage array: clear walk or accepted write; contents are never reset
    always_ff @(posedge i_clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (wr_ok_s) begin
            mem_r[i_wr_addr] <= i_wr_data;
        end
    end

    // Control FSM: CLEAR walks every entry once, RUN serves accesses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_L) begin
                        state_r   <= ST_RUN;
                        clr_cnt_r <= '0;
                        ready_r   <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + AW'(1'b1);
                    end
                end
                ST_RUN: begin
                    if (i_clr) begin
                        state_r   <= ST_CLEAR;
                        clr_cnt_r <= '0;
                        ready_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // First read stage and error pulse; data holds while a channel is idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld1_r  <= '0;
            data1_r <= '0;
            err_r   <= 1'b0;
        end else begin
            vld1_r <= rd_acc_s;
            err_r  <= err_s;
            for (int k = 0; k < RD_PORTS; k++) begin
                if (rd_acc_s[k]) begin
                    data1_r[k*RAM_WIDTH +: RAM_WIDTH] <= rd_val_s[k*RAM_WIDTH +: RAM_WIDTH];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [RD_PORTS-1:0]           vld2_r;
            logic [RD_PORTS*RAM_WIDTH-1:0] data2_r;

            // Optional output stage; keeps running during CLEAR so in-flight reads drain
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld2_r  <= '0;
                    data2_r <= '0;
                end else begin
                    vld2_r <= vld1_r;
                    for (int k = 0; k < RD_PORTS; k++) begin
                        if (vld1_r[k]) begin
                            data2_r[k*RAM_WIDTH +: RAM_WIDTH] <= data1_r[k*RAM_WIDTH +: RAM_WIDTH];
                        end
                    end
                end
            end

            assign o_rd_vld  = vld2_r;
            assign o_rd_data = data2_r;
        end else begin : g_no_out_reg
            assign o_rd_vld  = vld1_r;
            assign o_rd_data = data1_r;
        end
    endgenerate

    assign o_ready    = ready_r;
    assign o_addr_err = err_r;

endmodule

// File: tb/tb_ram_sdp_multird.sv
// Bench for ram_sdp_multird: a default instance and a 12-deep, registered-output,
// read-first instance share one random stimulus and are checked against an array model.
module tb_ram_sdp_multird;

    localparam int W   = 32;
    localparam int RDP = 2;
    localparam int AW  = 4;
    localparam int DW  = RDP * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            clr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic [RDP-1:0]  rd_en;
    logic [RDP*AW-1:0] rd_addr;

    logic [DW-1:0]   rd_data_o [2];
    logic [RDP-1:0]  rd_vld_o  [2];
    logic            ready_o   [2];
    logic            err_o     [2];

    ram_sdp_multird u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_o[0]), .o_rd_vld(rd_vld_o[0]),
        .o_ready(ready_o[0]), .o_addr_err(err_o[0])
    );

    ram_sdp_multird #(.RAM_DEPTH(12), .OUT_REG(1), .WR_BYPASS(0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_o[1]), .o_rd_vld(rd_vld_o[1]),
        .o_ready(ready_o[1]), .o_addr_err(err_o[1])
    );

    // Reference model state, one slot per instance
    int             depth_m [2] = '{16, 12};
    int             lat_m   [2] = '{1, 2};
    bit             byp_m   [2] = '{1'b1, 1'b0};
    logic [W-1:0]   mem_m   [2][16];
    int             clear_left_m [2];
    logic [RDP-1:0] s1_vld_m  [2];
    logic [DW-1:0]  s1_data_m [2];
    logic [RDP-1:0] exp_vld  [2];
    logic [DW-1:0]  exp_data [2];
    logic           exp_err  [2];
    logic           exp_rdy  [2];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            clear_left_m[i] = depth_m[i];
            s1_vld_m[i]     = '0;
            s1_data_m[i]    = '0;
            exp_vld[i]      = '0;
            exp_data[i]     = '0;
            exp_err[i]      = 1'b0;
            exp_rdy[i]      = 1'b0;
        end
    endtask

    // Applies one clock edge to the model using the inputs that were stable before it
    task automatic model_edge();
        logic [RDP-1:0] nv;
        logic [DW-1:0]  nd;
        logic           e;
        int             a;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                nv = '0;
                nd = '0;
                e  = 1'b0;
                if (clear_left_m[i] == 0) begin
                    for (int k = 0; k < RDP; k++) begin
                        if (rd_en[k]) begin
                            nv[k] = 1'b1;
                            a = int'(rd_addr[k*AW +: AW]);
                            if (a >= depth_m[i]) e = 1'b1;
                            else if (byp_m[i] && wr_en && int'(wr_addr) == a) nd[k*W +: W] = wr_data;
                            else nd[k*W +: W] = mem_m[i][a];
                        end
                    end
                    if (wr_en) begin
                        if (int'(wr_addr) >= depth_m[i]) e = 1'b1;
                        else mem_m[i][wr_addr] = wr_data;
                    end
                    if (clr) clear_left_m[i] = depth_m[i];
                end else begin
                    mem_m[i][depth_m[i] - clear_left_m[i]] = '0;
                    clear_left_m[i]--;
                end
                if (lat_m[i] == 1) begin
                    exp_vld[i] = nv;
                    for (int k = 0; k < RDP; k++)
                        if (nv[k]) exp_data[i][k*W +: W] = nd[k*W +: W];
                end else begin
                    exp_vld[i] = s1_vld_m[i];
                    for (int k = 0; k < RDP; k++)
                        if (s1_vld_m[i][k]) exp_data[i][k*W +: W] = s1_data_m[i][k*W +: W];
                    s1_vld_m[i] = nv;
                    for (int k = 0; k < RDP; k++)
                        if (nv[k]) s1_data_m[i][k*W +: W] = nd[k*W +: W];
                end
                exp_err[i] = e;
                exp_rdy[i] = (clear_left_m[i] == 0);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("ready%0d", i), 64'(ready_o[i]), 64'(exp_rdy[i]));
            check_eq($sformatf("err%0d", i),   64'(err_o[i]),   64'(exp_err[i]));
            check_eq($sformatf("vld%0d", i),   64'(rd_vld_o[i]), 64'(exp_vld[i]));
            check_eq($sformatf("data%0d", i),  64'(rd_data_o[i]), 64'(exp_data[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic idle();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = '0;
    endtask

    task automatic rand_in();
        clr     = ($urandom_range(0, 199) == 0);
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom);
        wr_data = $urandom;
        rd_en   = RDP'($urandom);
        rd_addr = (RDP*AW)'($urandom);
    endtask

    // Counts edges from reset release until each instance raises o_ready
    task automatic ready_latency(input string tag);
        int ca;
        int cb;
        ca = -1;
        cb = -1;
        for (int c = 1; c <= 30; c++) begin
            rd_en   = RDP'($urandom);
            rd_addr = (RDP*AW)'($urandom);
            step();
            if (ca < 0 && ready_o[0]) ca = c;
            if (cb < 0 && ready_o[1]) cb = c;
        end
        idle();
        check_eq({tag, "_a"}, 64'(ca), 64'(16));
        check_eq({tag, "_b"}, 64'(cb), 64'(12));
    endtask

    task automatic read_sweep();
        for (int a = 0; a < 16; a++) begin
            rd_en   = 2'b11;
            rd_addr = {AW'(15 - a), AW'(a)};
            step();
        end
        idle();
        repeat (2) step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 16; a++) mem_m[i][a] = '0;
        rst_n   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        idle();
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        ready_latency("rdy_lat");
        read_sweep();

        // Write then dual-channel read of the same address
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        step();
        idle(); rd_en = 2'b11; rd_addr = {4'd5, 4'd5};
        step();
        idle();
        repeat (2) step();

        // Same-address read/write collision
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h11111111;
        step();
        wr_data = 32'h22222222; rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        step();
        idle();
        repeat (2) step();

        // Out-of-range write and read (only the 12-deep instance flags these)
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hCAFEF00D; rd_en = 2'b10; rd_addr = {4'd14, 4'd0};
        step();
        idle(); rd_en = 2'b11; rd_addr = {4'd13, 4'd13};
        step();
        idle();
        repeat (2) step();

        // Clear request racing a read; reads during CLEAR are dropped
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h000000A5;
        step();
        idle(); clr = 1'b1; rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
        step();
        clr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rd_en   = RDP'($urandom);
            rd_addr = (RDP*AW)'($urandom);
            step();
        end
        rd_en = 2'b11; rd_addr = {4'd7, 4'd7};
        step();
        idle();
        repeat (2) step();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            rand_in();
            step();
        end
        idle();
        repeat (20) step();

        // Reset asserted mid-clear with the counter at 9
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (9) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) step();
        rst_n = 1'b1;
        ready_latency("rdy_lat_rst");
        read_sweep();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_multird.md
RAM_SDP_MULTIRD -- requirements
Module: ram_sdp_multird

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, data width in bits (1..512).
REQ-002 SHALL have parameter RAM_DEPTH, default 16, number of entries (2..65536); it need not be a power of two.
REQ-003 SHALL have parameter RD_PORTS, default 2, number of independent read channels (1..4).
REQ-004 SHALL have parameter OUT_REG, default 0; 0 gives a 1-cycle read latency, 1 adds an output register for a 2-cycle read latency.
REQ-005 SHALL have parameter WR_BYPASS, default 1; 1 gives write-first behaviour on a same-address collision, 0 gives read-first.
REQ-006 SHALL derive the local address width AW = max(1, ceil(log2(RAM_DEPTH))).
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock for all logic.
REQ-008 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port i_clr, input, 1 bit: single-cycle pulse that starts a full memory clear.
REQ-010 SHALL have port i_wr_en, input, 1 bit: write enable.
REQ-011 SHALL have port i_wr_addr, input, AW bits: write address.
REQ-012 SHALL have port i_wr_data, input, RAM_WIDTH bits: write data.
REQ-013 SHALL have port i_rd_en, input, RD_PORTS bits: per-channel read request.
REQ-014 SHALL have port i_rd_addr, input, RD_PORTS*AW bits: packed read addresses, with channel k at bits [k*AW +: AW].
REQ-015 SHALL have port o_rd_data, output, RD_PORTS*RAM_WIDTH bits: packed read data, with channel k at bits [k*RAM_WIDTH +: RAM_WIDTH].
REQ-016 SHALL have port o_rd_vld, output, RD_PORTS bits: per-channel read data valid.
REQ-017 SHALL have port o_ready, output, 1 bit: high when the block accepts reads and writes.
REQ-018 SHALL have port o_addr_err, output, 1 bit: single-cycle pulse on any accepted access with an address >= RAM_DEPTH.

Function
REQ-019 SHALL implement a FSM with states CLEAR and RUN.
REQ-020 SHALL, in CLEAR, write zero to one entry per cycle using an internal counter running 0..RAM_DEPTH-1, then enter RUN on the cycle after address RAM_DEPTH-1 is written; CLEAR lasts exactly RAM_DEPTH cycles.
REQ-021 SHALL hold o_ready = 1 only in RUN.
REQ-022 SHALL, while in CLEAR, ignore i_wr_en and i_rd_en, leave o_rd_vld low for new requests, and not assert o_addr_err.
REQ-023 SHALL, when i_clr is sampled high in RUN, enter CLEAR on the next cycle and restart the counter at 0; an access presented in the same cycle as i_clr is still performed.
REQ-024 SHALL ignore i_clr while already in CLEAR; the counter does not restart.
REQ-025 SHALL, in RUN, write i_wr_data to i_wr_addr at the clock edge when i_wr_en = 1 and i_wr_addr < RAM_DEPTH.
REQ-026 SHALL, in RUN, assert o_rd_vld[k] exactly 1+OUT_REG cycles after i_rd_en[k] is sampled high, for one cycle per request, with the matching data on channel k.
REQ-027 SHALL accept back-to-back reads on every channel, one per cycle, as a fully pipelined path with no stalls.
REQ-028 SHALL let all channels read the same or different addresses in the same cycle with no interaction between them.
REQ-029 SHALL, on a read and a write to the same address in the same cycle, return i_wr_data when WR_BYPASS = 1 and the previous contents when WR_BYPASS = 0.
REQ-030 SHALL, for a read with address >= RAM_DEPTH, still assert o_rd_vld with all-zero data.
REQ-031 SHALL not modify memory on a write with address >= RAM_DEPTH.
REQ-032 SHALL assert o_addr_err one cycle after any such read or write, as one pulse even if several channels are in error at once.
REQ-033 SHALL keep o_rd_data[k] at its last value while o_rd_vld[k] = 0.
REQ-034 SHALL complete read requests accepted in RUN before an i_clr, at their normal latency, with data from before the clear.

Reset
REQ-035 SHALL, on i_rst_n = 0, immediately and asynchronously drive o_rd_vld = 0, o_rd_data = 0, o_addr_err = 0 and o_ready = 0, and clear all pipeline registers.
REQ-036 SHALL, on i_rst_n = 0, set the FSM to CLEAR with the counter at 0.
REQ-037 SHALL, after i_rst_n deasserts, run one full CLEAR sequence so that memory reads as all zeros once o_ready rises.
REQ-038 SHALL, on a reset asserted during CLEAR or RUN, abort the current operation and restart from REQ-036 on release.
REQ-039 SHALL reset only the control and output registers; memory contents are not reset directly.

Verification
REQ-040 Release reset with defaults -> o_ready rises exactly 16 cycles after the first clock edge with i_rst_n = 1, and reads of addresses 0..15 on both channels return 0.
REQ-041 Write 0xDEADBEEF to address 5, then the next cycle read address 5 on channel 0 and address 5 on channel 1 -> both o_rd_vld bits high one cycle later with 0xDEADBEEF; with OUT_REG = 1 the response comes two cycles later.
REQ-042 Hold 0x11111111 at address 3, then write 0x22222222 to address 3 while reading address 3 in the same cycle -> 0x22222222 with WR_BYPASS = 1, 0x11111111 with WR_BYPASS = 0.
REQ-043 RAM_DEPTH = 12, write address 13, read address 14 on channel 1 -> one o_addr_err pulse, o_rd_vld[1] high with data 0, memory unchanged.
REQ-044 Write 0xA5 to address 7, pulse i_clr while reading address 7 -> the read returns 0xA5, o_ready is low for 16 cycles, a later read of address 7 returns 0, and reads issued while o_ready = 0 give no o_rd_vld.
REQ-045 Assert i_rst_n = 0 mid-CLEAR at counter value 9 -> outputs go to zero asynchronously, and after release the clear restarts from 0 and takes the full 16 cycles.
